// File: rtl/llc_stage_fifo_pkg.sv
// Shared LLC cache types: inter-stage packet layouts, their widths and FIFO sizing helpers.
package llc_stage_fifo_pkg;

    localparam int unsigned LLC_ADDR_W = 32;
    localparam int unsigned LLC_ID_W   = 8;
    localparam int unsigned LLC_WAY_W  = 4;
    localparam int unsigned LLC_LINE_W = 64;

    typedef enum logic [1:0] {
        LLC_OP_READ  = 2'd0,
        LLC_OP_WRITE = 2'd1,
        LLC_OP_EVICT = 2'd2,
        LLC_OP_INV   = 2'd3
    } llc_op_e;

    typedef struct packed {
        logic [LLC_ID_W-1:0]   id;
        llc_op_e               op;
        logic [LLC_ADDR_W-1:0] addr;
    } fifo_mem_packet;

    typedef struct packed {
        logic [LLC_ID_W-1:0]   id;
        llc_op_e               op;
        logic [LLC_ADDR_W-1:0] addr;
        logic [LLC_LINE_W-1:0] line;
    } fifo_mem_lookup_packet;

    typedef struct packed {
        logic [LLC_ID_W-1:0]   id;
        llc_op_e               op;
        logic                  hit;
        logic [LLC_WAY_W-1:0]  way;
        logic [LLC_LINE_W-1:0] line;
    } fifo_look_proc_packet;

    localparam int unsigned FIFO_MEM_PACKET_W        = $bits(fifo_mem_packet);
    localparam int unsigned FIFO_MEM_LOOKUP_PACKET_W = $bits(fifo_mem_lookup_packet);
    localparam int unsigned FIFO_LOOK_PROC_PACKET_W  = $bits(fifo_look_proc_packet);

    // Pointer width for a modulo-depth index; a single entry still needs one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/llc_stage_fifo_ptr.sv
// Modulo-DEPTH pointer with increment enable and clear; wraps explicitly from DEPTH-1 to 0.
module llc_stage_fifo_ptr
    import llc_stage_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          inc,
    output logic [ptr_width(DEPTH)-1:0]   ptr
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/llc_stage_fifo.sv
// Parametrised LLC inter-stage FIFO: any depth, optional same-cycle bypass,
// programmable almost-full threshold and sticky overflow/underflow flags.
module llc_stage_fifo
    import llc_stage_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    parameter bit          BYPASS     = 1'b0,
    parameter int unsigned AF_THRESH  = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full,
    output logic [$clog2(DEPTH+1)-1:0]    usage,
    output logic                          overflow_err,
    output logic                          underflow_err
);

    localparam int unsigned UW = $clog2(DEPTH + 1);
    localparam int unsigned PW = ptr_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [UW-1:0]         count;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic                  bypass_c;
    logic                  pass_through_c;
    logic                  push_ok_c;
    logic                  pop_ok_c;
    logic                  wr_en_c;
    logic                  rd_en_c;

    // Status is a pure function of the registered count.
    assign empty       = (count == '0);
    assign full        = (count == UW'(DEPTH));
    assign almost_full = (count >= UW'(AF_THRESH));
    assign usage       = count;

    assign bypass_c       = BYPASS && empty && push;
    assign valid_out      = !empty || bypass_c;
    assign pop_ok_c       = pop && valid_out;
    assign push_ok_c      = push && (!full || pop);
    // Empty bypass with a simultaneous pop consumes the packet without storing it.
    assign pass_through_c = bypass_c && pop;
    assign wr_en_c        = push_ok_c && !pass_through_c && !flush;
    assign rd_en_c        = pop_ok_c && !pass_through_c && !flush;

    always_comb begin
        data_out = '0;
        if (!empty) begin
            data_out = mem[rd_ptr];
        end else if (bypass_c) begin
            data_out = data_in;
        end
    end

    llc_stage_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (wr_en_c),
        .ptr (wr_ptr)
    );

    llc_stage_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (rd_en_c),
        .ptr (rd_ptr)
    );

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (flush) begin
            count <= '0;
        end else begin
            if (wr_en_c && !rd_en_c) begin
                count <= count + UW'(1);
            end else if (rd_en_c && !wr_en_c) begin
                count <= count - UW'(1);
            end
            if (push && !push_ok_c) begin
                overflow_err <= 1'b1;
            end
            if (pop && !valid_out) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_llc_stage_fifo.sv
// Bench for llc_stage_fifo: three configurations share one stimulus stream and are
// checked every cycle against a list-based reference model.
module tb_llc_stage_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       push;
    logic       pop;
    logic [7:0] data_in;

    always #5 clk = ~clk;

    logic [7:0] dout_a, dout_b, dout_c;
    logic       vout_a, vout_b, vout_c;
    logic       emp_a, emp_b, emp_c;
    logic       ful_a, ful_b, ful_c;
    logic       af_a, af_b, af_c;
    logic       ovf_a, ovf_b, ovf_c;
    logic       unf_a, unf_b, unf_c;
    logic [1:0] use_a;
    logic [2:0] use_b;
    logic [0:0] use_c;

    llc_stage_fifo #(.DATA_WIDTH(8), .DEPTH(3), .BYPASS(1'b0)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
        .data_out(dout_a), .valid_out(vout_a), .empty(emp_a), .full(ful_a),
        .almost_full(af_a), .usage(use_a), .overflow_err(ovf_a), .underflow_err(unf_a)
    );

    llc_stage_fifo #(.DATA_WIDTH(8), .DEPTH(4), .BYPASS(1'b1), .AF_THRESH(3)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
        .data_out(dout_b), .valid_out(vout_b), .empty(emp_b), .full(ful_b),
        .almost_full(af_b), .usage(use_b), .overflow_err(ovf_b), .underflow_err(unf_b)
    );

    llc_stage_fifo #(.DATA_WIDTH(8), .DEPTH(1), .BYPASS(1'b0)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
        .data_out(dout_c), .valid_out(vout_c), .empty(emp_c), .full(ful_c),
        .almost_full(af_c), .usage(use_c), .overflow_err(ovf_c), .underflow_err(unf_c)
    );

    int dep[3]   = '{3, 4, 1};
    int byp[3]   = '{0, 1, 0};
    int afth[3]  = '{2, 3, 0};

    // Reference model: each FIFO is an ordered list, head at index 0.
    logic [7:0] m_q [3][4];
    int         m_n [3];
    logic       m_ovf [3];
    logic       m_unf [3];

    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic pu, input logic po,
                        input logic [7:0] d);
        @(negedge clk);
        rst = r; flush = f; push = pu; pop = po; data_in = d;
        #1;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] g_d;
            logic [2:0] g_u;
            logic       g_v, g_e, g_f, g_af, g_o, g_un;
            logic       vis;
            logic [7:0] e_d;
            case (i)
                0: begin g_d = dout_a; g_u = 3'(use_a); g_v = vout_a; g_e = emp_a;
                         g_f = ful_a; g_af = af_a; g_o = ovf_a; g_un = unf_a; end
                1: begin g_d = dout_b; g_u = use_b; g_v = vout_b; g_e = emp_b;
                         g_f = ful_b; g_af = af_b; g_o = ovf_b; g_un = unf_b; end
                default: begin g_d = dout_c; g_u = 3'(use_c); g_v = vout_c; g_e = emp_c;
                         g_f = ful_c; g_af = af_c; g_o = ovf_c; g_un = unf_c; end
            endcase
            vis = (m_n[i] > 0) || (byp[i] != 0 && pu);
            e_d = (m_n[i] > 0) ? m_q[i][0] : (vis ? d : 8'h00);
            check($sformatf("u%0d.valid_out", i),     32'(g_v),  32'(vis));
            check($sformatf("u%0d.data_out", i),      32'(g_d),  32'(e_d));
            check($sformatf("u%0d.empty", i),         32'(g_e),  32'(m_n[i] == 0));
            check($sformatf("u%0d.full", i),          32'(g_f),  32'(m_n[i] == dep[i]));
            check($sformatf("u%0d.almost_full", i),   32'(g_af), 32'(m_n[i] >= afth[i]));
            check($sformatf("u%0d.usage", i),         32'(g_u),  32'(m_n[i]));
            check($sformatf("u%0d.overflow_err", i),  32'(g_o),  32'(m_ovf[i]));
            check($sformatf("u%0d.underflow_err", i), 32'(g_un), 32'(m_unf[i]));

            // Advance the model to the state after this clock edge.
            if (r) begin
                m_n[i] = 0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
            end else if (f) begin
                m_n[i] = 0;
            end else begin
                if (pu && m_n[i] == dep[i] && !po) m_ovf[i] = 1'b1;
                if (po && !vis) m_unf[i] = 1'b1;
                if (!(byp[i] != 0 && m_n[i] == 0 && pu && po)) begin
                    if (po && m_n[i] > 0) begin
                        for (int k = 0; k < 3; k++) m_q[i][k] = m_q[i][k+1];
                        m_n[i]--;
                    end
                    if (pu && m_n[i] < dep[i]) begin
                        m_q[i][m_n[i]] = d;
                        m_n[i]++;
                    end
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 3; i++) begin
            m_n[i] = 0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
            for (int k = 0; k < 4; k++) m_q[i][k] = 8'h00;
        end
        rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;
        repeat (3) @(posedge clk);

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // Fill/drain in order, repeated for pointer wrap.
        for (int rep = 0; rep < 4; rep++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'h0A);
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'h0B);
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'h0C);
            repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        end
        // Write-through at full, then drain.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h02);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h03);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h0D);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        // Bypass with and without pop from empty.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h05);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h06);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        // Overflow, underflow, flush keeps flags, reset clears them.
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h20 + k));
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        // Flush wins over a same-cycle push.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h31);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h32);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h33);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Randomised traffic, alternating fill-biased and drain-biased phases.
        for (int n = 0; n < 3000; n++) begin
            int push_pct;
            push_pct = ((n / 250) % 2 == 0) ? 70 : 35;
            step(($urandom_range(199) == 0),
                 ($urandom_range(39) == 0),
                 ($urandom_range(99) < push_pct),
                 ($urandom_range(99) < 50),
                 8'($urandom_range(255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
